// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ valid/ready requesters. It issues at most one write per cycle and
// throttles on full/almostfull so that a conforming FIFO never overflows.
// Every issued write is expected to be acknowledged one cycle after the FIFO
// samples it; a missing acknowledge is counted in drop_cnt (saturating) and
// latched in the sticky drop_err flag.
//
// Optional feature: define FIFO_ARB_BURST_EN to let a granted requester keep
// priority for up to BURST_LEN consecutive beats. Without the macro, priority
// rotates after every beat.
//
// Handshake: a beat from requester i transfers on a rising edge where
// req_valid[i] && req_ready[i]. req_ready is combinational, may depend on
// req_valid, and is one-hot or zero. A requester that is not ready must hold
// its valid and data stable; this block never drops a beat it accepted.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          drop_err
);

  localparam int ID_W = $clog2(N_REQ);

  // Parameter sanity: the arbiter supports 2..8 requesters and a burst
  // length of at least one beat.
  localparam bit PARAMS_OK = (N_REQ >= 2) && (N_REQ <= 8) && (BURST_LEN >= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("fifo_wr_arbiter: unsupported N_REQ or BURST_LEN");
  end

  // Arbitration state: the requester that took the most recent beat.
  logic [ID_W-1:0]       last_grant;
  // One write was driven last cycle; its acknowledge is due this cycle.
  logic                  ack_pend;

  // Combinational selection results.
  logic                  can_issue;
  logic                  sel_found;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       cand;
  logic                  xfer;
  logic [FIFO_WIDTH-1:0] sel_data;

  // A write already in flight is not yet visible in the flags, so with
  // almostfull set it would fill the last slot; hold off for that cycle.
  always_comb begin
    can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  // Consecutive beats taken by last_grant in the current burst (0 = none).
  logic [BW-1:0] burst_cnt;
  logic          burst_hold;
  logic [BW-1:0] burst_nxt;

  // The current burst owner keeps priority while it stays valid and the
  // burst has not yet reached BURST_LEN beats.
  always_comb begin
    burst_hold = (burst_cnt != '0) && req_valid[last_grant];
    burst_nxt  = burst_hold ? (burst_cnt + BW'(1)) : BW'(1);
  end

  // Burst length tracking: stall cycles hold the count, a dropped valid
  // ends the burst, reaching BURST_LEN clears it so rotation resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= (int'(burst_nxt) >= BURST_LEN) ? '0 : burst_nxt;
    end else if (!req_valid[last_grant]) begin
      burst_cnt <= '0;
    end
  end
`else
  logic burst_hold;

  // Without bursts priority always rotates after a beat.
  always_comb begin
    burst_hold = 1'b0;
  end
`endif

  // Round-robin pick: search from last_grant+1 and take the first valid
  // requester, unless a burst owner keeps priority.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    if (burst_hold) begin
      sel_found = 1'b1;
      sel_id    = last_grant;
    end
    for (int off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((int'(last_grant) + off) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Ready goes only to the selected requester, and never during reset.
  always_comb begin
    xfer      = sel_found && can_issue && !rst;
    req_ready = xfer ? (N_REQ'(1) << sel_id) : '0;
    sel_data  = req_data[sel_id*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Registered write port and rotation pointer; data and id hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
      last_grant   <= ID_W'(N_REQ - 1);
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) begin
        fifo_data_in <= sel_data;
        grant_id     <= sel_id;
        last_grant   <= sel_id;
      end
    end
  end

  // Acknowledge cross-check: a write driven last cycle must be acknowledged
  // now; an acknowledge with nothing pending is ignored. Reset abandons any
  // write still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_pend <= 1'b0;
      drop_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      ack_pend <= fifo_wr_en;
      if (ack_pend && !fifo_wr_ack) begin
        drop_err <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
